// File: rtl/fp_norm_round.sv
// Floating-point normalize-and-round stage.
// Two-stage valid/ready pipeline sitting between an arithmetic datapath
// and the pack stage:
//   S1 normalizes the unnormalized significand (one-bit right shift or a
//      leading-zero left shift) and folds shifted-out bits into sticky.
//   S2 rounds to nearest-even, renormalizes a rounding carry and
//      classifies the result as nan / inf / zero / normal.
// Overflow saturates to infinity; underflow flushes to zero (no subnormals).
module fp_norm_round #(
  parameter int FW = 23,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW+1:0] in_exp,
  input  logic [FW+3:0] in_sig,
  input  logic          in_sticky,
  input  logic          in_inf,
  input  logic          in_nan,
  input  logic          in_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_exponent,
  output logic [FW:0]   out_significant,
  output logic          out_sign,
  output logic          out_inf,
  output logic          out_nan,
  output logic          out_zero
);

  // Leading-zero counter width: must represent FW+3 (all-zero input).
  localparam int LW = $clog2(FW + 4);
  // Internal exponent width: headroom for the input range, +1 on either
  // normalize or round carry, and minus a full leading-zero shift.
  localparam int IW = EW + 3 + LW;

  localparam logic signed [IW-1:0] EXP_ONE  = IW'(1);
  localparam logic signed [IW-1:0] EXP_ZERO = '0;
  localparam logic signed [IW-1:0] EXP_MAX  = IW'((1 << EW) - 1);

  // Count of leading zeros in a (FW+3)-bit field; FW+3 when all zero.
  function automatic logic [LW-1:0] lzc(input logic [FW+2:0] v);
    logic [LW-1:0] n;
    n = LW'(FW + 3);
    // Scanning upward means the highest set bit is the last one to write n.
    for (int i = 0; i <= FW + 2; i++) begin
      if (v[i]) n = LW'(FW + 2 - i);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic r1_valid;
  logic r2_valid;
  logic w_s1_adv;
  logic w_s2_adv;

  assign w_s2_adv  = !r2_valid || out_ready;
  assign w_s1_adv  = !r1_valid || w_s2_adv;
  assign in_ready  = !r1_valid || w_s1_adv;
  assign out_valid = r2_valid;

  // ---------------------------------------------------------------------
  // S1: normalize
  // ---------------------------------------------------------------------
  logic [FW+2:0]          w_sig_lo;
  logic [LW-1:0]          w_lzc;
  logic signed [IW-1:0]   w_exp_in;
  logic signed [IW-1:0]   w_lzc_ext;
  logic [FW+2:0]          w_n1_sig;
  logic signed [IW-1:0]   w_n1_exp;
  logic                   w_n1_sticky;
  logic                   w_n1_zero;

  assign w_sig_lo  = in_sig[FW+2:0];
  assign w_lzc     = lzc(w_sig_lo);
  assign w_exp_in  = {{(IW-EW-2){in_exp[EW+1]}}, in_exp};
  assign w_lzc_ext = {{(IW-LW){1'b0}}, w_lzc};
  assign w_n1_zero = in_zero || (in_sig == '0);

  // Choose between the right-shift (value >= 2) and left-shift normalizations.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_n1_sig    = w_sig_lo << w_lzc;
    w_n1_exp    = w_exp_in - w_lzc_ext;
    w_n1_sticky = in_sticky;
    if (in_sig[FW+3]) begin
      w_n1_sig    = in_sig[FW+3:1];
      w_n1_exp    = w_exp_in + EXP_ONE;
      w_n1_sticky = in_sticky | in_sig[0];
    end
  end

  logic [FW+2:0]        r1_sig;
  logic signed [IW-1:0] r1_exp;
  logic                 r1_sticky;
  logic                 r1_zero;
  logic                 r1_inf;
  logic                 r1_nan;
  logic                 r1_sign;

  // S1 register: load a new operand whenever the stage advances.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_sig    <= '0;
      r1_exp    <= '0;
      r1_sticky <= 1'b0;
      r1_zero   <= 1'b0;
      r1_inf    <= 1'b0;
      r1_nan    <= 1'b0;
      r1_sign   <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sig    <= w_n1_sig;
        r1_exp    <= w_n1_exp;
        r1_sticky <= w_n1_sticky;
        r1_zero   <= w_n1_zero;
        r1_inf    <= in_inf;
        r1_nan    <= in_nan;
        r1_sign   <= in_sign;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: round and classify
  // ---------------------------------------------------------------------
  logic                 w_inc;
  logic [FW+1:0]        w_sum;
  logic [FW:0]          w_rsig;
  logic signed [IW-1:0] w_rexp;
  logic                 w_ovf;
  logic                 w_unf;
  logic                 w_nan;
  logic                 w_inf;
  logic                 w_zero;

  // Round up when guard is set and we are above half-ULP or tied with odd LSB.
  assign w_inc = r1_sig[1] & (r1_sig[0] | r1_sticky | r1_sig[2]);
  assign w_sum = {1'b0, r1_sig[FW+2:2]} + {{(FW+1){1'b0}}, w_inc};

  // A carry out of the significand means the value reached 2.0.
  always_comb begin
    w_rsig = w_sum[FW:0];
    w_rexp = r1_exp;
    if (w_sum[FW+1]) begin
      w_rsig = w_sum[FW+1:1];
      w_rexp = r1_exp + EXP_ONE;
    end
  end

  assign w_ovf  = !r1_zero && (w_rexp >= EXP_MAX);
  assign w_unf  = w_rexp <= EXP_ZERO;
  assign w_nan  = r1_nan;
  assign w_inf  = !w_nan && (r1_inf || w_ovf);
  assign w_zero = !w_nan && !w_inf && (r1_zero || w_unf);

  logic [EW-1:0] r2_exp;
  logic [FW:0]   r2_sig;
  logic          r2_sign;
  logic          r2_inf;
  logic          r2_nan;
  logic          r2_zero;

  // S2 register: special results carry zero exponent and significand.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: output data registers are reset too, so the pack stage sees
    // clean zeros while reset is held rather than stale contents.
    if (rst) begin
      r2_valid <= 1'b0;
      r2_exp   <= '0;
      r2_sig   <= '0;
      r2_sign  <= 1'b0;
      r2_inf   <= 1'b0;
      r2_nan   <= 1'b0;
      r2_zero  <= 1'b0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign;
        r2_nan  <= w_nan;
        r2_inf  <= w_inf;
        r2_zero <= w_zero;
        if (w_nan || w_inf || w_zero) begin
          r2_exp <= '0;
          r2_sig <= '0;
        end else begin
          r2_exp <= w_rexp[EW-1:0];
          r2_sig <= w_rsig;
        end
      end
    end
  end

  assign out_exponent    = r2_exp;
  assign out_significant = r2_sig;
  assign out_sign        = r2_sign;
  assign out_inf         = r2_inf;
  assign out_nan         = r2_nan;
  assign out_zero        = r2_zero;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round (default FW=23, EW=8).
// Expected results are queued when an operand is accepted and compared in
// order when the DUT hands a result downstream.
`timescale 1ns/1ps
module tb_fp_norm_round;

  localparam int FW = 23;
  localparam int EW = 8;
  localparam int SW = FW + 4;

  typedef struct packed {
    logic          sign;
    logic          inf;
    logic          nan;
    logic          zero;
    logic [EW-1:0] exp;
    logic [FW:0]   sig;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [EW+1:0] in_exp = '0;
  logic [SW-1:0] in_sig = '0;
  logic          in_sticky = 1'b0;
  logic          in_inf = 1'b0;
  logic          in_nan = 1'b0;
  logic          in_zero = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [EW-1:0] out_exponent;
  logic [FW:0]   out_significant;
  logic          out_sign;
  logic          out_inf;
  logic          out_nan;
  logic          out_zero;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  res_t got;
  res_t held;
  logic hold_pend = 1'b0;

  fp_norm_round #(.FW(FW), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
    .in_sticky(in_sticky), .in_inf(in_inf), .in_nan(in_nan), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exponent(out_exponent), .out_significant(out_significant),
    .out_sign(out_sign), .out_inf(out_inf), .out_nan(out_nan), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  assign got = '{sign: out_sign, inf: out_inf, nan: out_nan, zero: out_zero,
                 exp: out_exponent, sig: out_significant};

  // Scoreboard monitor: in-order compare on transfer, stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b %h required valid=1 %h", out_valid, got, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h with no operand outstanding", got);
        end else begin
          res_t e;
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result: got s=%b i=%b n=%b z=%b e=%h m=%h required s=%b i=%b n=%b z=%b e=%h m=%h",
                     got.sign, got.inf, got.nan, got.zero, got.exp, got.sig,
                     e.sign, e.inf, e.nan, e.zero, e.exp, e.sig);
          end
        end
      end
      hold_pend = (out_valid === 1'b1) && !out_ready;
      held      = got;
    end
  end

  function automatic res_t mk(input logic s, input logic fi, input logic fn, input logic fz,
                              input logic [EW-1:0] x, input logic [FW:0] g);
    res_t r;
    r.sign = s; r.inf = fi; r.nan = fn; r.zero = fz; r.exp = x; r.sig = g;
    return r;
  endfunction

  // Reference model: arithmetic on the significand as an integer, rounding
  // decided by comparing the discarded remainder against half an ULP.
  function automatic res_t model(input logic s, input logic [EW+1:0] e, input logic [SW-1:0] sg,
                                 input logic st, input logic fi, input logic fn, input logic fz);
    res_t   r;
    longint n, ex, keep, rem;
    logic   z, up, sticky;
    r = '0;
    r.sign = s;
    n = longint'(sg);
    ex = longint'($signed(e));
    sticky = st;
    z = fz || (sg == '0);
    if (sg != '0) begin
      if (n >= (longint'(1) << (FW + 3))) begin
        sticky = sticky || ((n & 1) != 0);
        n = n >> 1;
        ex = ex + 1;
      end else begin
        while (n < (longint'(1) << (FW + 2))) begin
          n = n << 1;
          ex = ex - 1;
        end
      end
    end
    keep = n >> 2;
    rem  = n & 3;
    up = (rem == 3) || (rem == 2 && (sticky || (keep & 1) != 0));
    if (up) keep = keep + 1;
    if (keep == (longint'(1) << (FW + 1))) begin
      keep = keep >> 1;
      ex = ex + 1;
    end
    if (fn) r.nan = 1'b1;
    else if (fi || (!z && ex >= (longint'(1) << EW) - 1)) r.inf = 1'b1;
    else if (z || ex <= 0) r.zero = 1'b1;
    else begin
      r.exp = ex[EW-1:0];
      r.sig = keep[FW:0];
    end
    return r;
  endfunction

  // Present one operand and hold it until accepted; call at posedge+1.
  task automatic send(input logic s, input logic [EW+1:0] e, input logic [SW-1:0] sg,
                      input logic st, input logic fi, input logic fn, input logic fz,
                      input res_t x);
    int   n;
    logic ok;
    in_sign = s; in_exp = e; in_sig = sg; in_sticky = st;
    in_inf = fi; in_nan = fn; in_zero = fz;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after 200 cycles, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sb.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_m(input logic s, input logic [EW+1:0] e, input logic [SW-1:0] sg,
                        input logic st, input logic fi, input logic fn, input logic fz);
    send(s, e, sg, st, fi, fn, fz, model(s, e, sg, st, fi, fn, fz));
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || got !== res_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b %h required valid=0 all zero", out_valid, got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(1'b0, 10'd127, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 24'h800000));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_due: out_valid=%b two cycles after accept, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    // carry on round renormalizes to 1.0 with exponent + 1
    send(1'b0, 10'd127, 27'h3FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd128, 24'h800000));
    // tie with even LSB stays, tie with odd LSB rounds up
    send(1'b0, 10'd127, 27'h2000002, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 24'h800000));
    send(1'b1, 10'd127, 27'h2000006, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 24'h800002));
    // tie broken by incoming sticky
    send(1'b0, 10'd127, 27'h2000002, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 24'h800001));
    // right shift: shifted-out bit joins sticky and breaks the tie
    send(1'b0, 10'd127, 27'h4000005, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd128, 24'h800001));
    send(1'b0, 10'd127, 27'h4000002, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd128, 24'h800000));
    // overflow by normalization and by rounding carry
    send(1'b0, 10'd254, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 24'h0));
    send(1'b1, 10'd254, 27'h3FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 24'h0));
    // largest normal exponent
    send(1'b0, 10'd254, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd254, 24'h800000));
    // left shift by 5: exp 10 stays normal, exp 3 underflows
    send(1'b0, 10'd10,  27'h0100000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 24'h800000));
    send(1'b1, 10'd3,   27'h0100000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 24'h0));
    // smallest normal exponent and the step below it
    send(1'b0, 10'd1,   27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 24'h800000));
    send(1'b0, 10'd0,   27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 24'h0));
    // all-zero significand, and special flags with priority
    send(1'b1, 10'd100, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 24'h0));
    send(1'b0, 10'd127, 27'h2000000, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 24'h0));
    send(1'b1, 10'd127, 27'h2000000, 1'b0, 1'b1, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 24'h0));
    send(1'b0, 10'd127, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 24'h0));
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 10'd100, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 24'h800000));
        send(1'b1, 10'd101, 27'h2000004, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd101, 24'h800001));
        send(1'b0, 10'd102, 27'h2000008, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd102, 24'h800002));
        send(1'b1, 10'd103, 27'h200000C, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd103, 24'h800003));
      end
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: got %b after two accepts, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_out_valid: got %b while stalled, required 1", out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          logic [EW+1:0] e;
          logic [SW-1:0] sg;
          int            pick;
          e    = EW'(0) + 10'($urandom_range(0, 300)) - 10'd20;
          sg   = SW'($urandom) >> $urandom_range(0, SW);
          pick = $urandom_range(0, 15);
          send_m(1'($urandom), e, sg, 1'($urandom), pick == 0, pick == 1, pick == 2);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(1'b0, 10'd127, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 24'h800000));
    send(1'b0, 10'd120, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd120, 24'h800000));
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || got !== res_t'('0)) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b %h required valid=0 all zero", out_valid, got);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_ready: got %b after release, required 1", in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale: out_valid=%b %0d cycles after release, required 0", out_valid, k);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_directed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 Parameter FW, default 23, fraction width excluding the hidden bit.
REQ-002 Parameter EW, default 8, exponent width; bias = 2^(EW-1)-1.
REQ-003 clk  input  1  clock; the block has one clock and all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  input operand valid.
REQ-006 in_ready  output  1  block can accept an input this cycle.
REQ-007 in_sign  input  1  result sign.
REQ-008 in_exp  input  EW+2  two's-complement biased exponent that belongs with in_sig.
REQ-009 in_sig  input  FW+4  unnormalized significand, value in [0,4): bit FW+3 weighs 2^1, bit FW+2 weighs 2^0, bits FW+1..2 are fraction, bit 1 is guard, bit 0 is round.
REQ-010 in_sticky  input  1  OR of all bits below the round bit.
REQ-011 in_inf, in_nan, in_zero  input  1 each  special-operand flags from the datapath.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream pack stage accepts the result.
REQ-014 out_exponent  output  EW  final biased exponent.
REQ-015 out_significant  output  FW+1  normalized significand, hidden bit at bit FW.
REQ-016 out_sign, out_inf, out_nan, out_zero  output  1 each  final flags for the pack stage.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 normalizes and S2 rounds and classifies; latency is 2 cycles from accepted input to out_valid with no stall.
REQ-018 Each stage SHALL hold a valid bit; a stage advances when it is empty or the next stage advances; S2 advances when out_ready=1.
REQ-019 in_ready SHALL equal (!s1_valid | s1_advance), and an input SHALL be accepted only when in_valid and in_ready are both high.
REQ-020 Under stall the outputs SHALL hold stable, and no accepted operand SHALL be dropped or duplicated.
REQ-021 S1: if in_sig[FW+3]=1, the significand SHALL shift right by 1 with exp+1, and the shifted-out bit SHALL OR into sticky.
REQ-022 S1: otherwise the significand SHALL shift left by the leading-zero count of in_sig[FW+2:0] with exp minus that count; an all-zero significand SHALL set zero.
REQ-023 S2 SHALL round to nearest-even using the LSB (bit 2), guard, and round|sticky; increment when guard & (round | sticky | lsb).
REQ-024 A rounding carry to 2.0 SHALL renormalize to 1.0 with exp+1.
REQ-025 Overflow: a post-round exp >= 2^EW-1 SHALL set out_inf=1.
REQ-026 Underflow: a post-round exp <= 0 SHALL flush to out_zero=1 (no subnormals), keeping the sign.
REQ-027 Flag priority on the outputs SHALL be nan > inf > zero > normal; for a normal result the in_* flags pass through unchanged, and out_sign always equals in_sign.
REQ-028 When out_inf, out_nan, or out_zero is set, out_exponent and out_significant SHALL be driven to 0.

Reset
REQ-029 While rst=1, all valid bits SHALL be 0 immediately (asynchronously) and all data outputs 0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Assertion of reset mid-operation SHALL discard all in-flight operands, and no out_valid SHALL appear from them after release.

Verification
REQ-032 1.0 (FW=23): in_sig=0x0800000<<2, in_exp=127, sticky=0 -> two cycles later out_exponent=127, out_significant=0x800000.
REQ-033 Carry on round: in_sig bits FW+2..0 all 1, in_exp=127 -> out_exponent=128, out_significant=0x800000.
REQ-034 Tie to even: LSB=0, guard=1, round=0, sticky=0 -> no increment; the same case with LSB=1 -> increment.
REQ-035 Overflow: in_sig[FW+3]=1, in_exp=254 -> out_inf=1, out_exponent=0; leading-zero input with in_exp=3 needing shift 5 -> out_zero=1.
REQ-036 Backpressure: stream 4 operands while holding out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, outputs hold stable, all 4 results emerge in order.
REQ-037 Apply reset with S1 and S2 full -> out_valid=0 in the same cycle, in_ready=1 after release, no stale output.
